// File: rtl/smul_pkg.sv
// smul_pkg: shared state type and width/sign-position helpers for the sign-magnitude multiplier and divider
package smul_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  function automatic int op_w(input int w);
    return w + 1;
  endfunction
  function automatic int prod_w(input int w);
    return 2 * w + 1;
  endfunction
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
  function automatic int op_sign(input int w);
    return w;
  endfunction
  function automatic int prod_sign(input int w);
    return 2 * w;
  endfunction
endpackage

// File: rtl/sm_shift_add_mul_step.sv
// smul_step: one shift-add step, conditional add of x into a then logical right shift of {a,q}
module smul_step
  import smul_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [op_w(WIDTH)-1:0] a,
  input  logic [WIDTH-1:0]       q,
  input  logic [WIDTH-1:0]       x,
  output logic [op_w(WIDTH)-1:0] a_n,
  output logic [WIDTH-1:0]       q_n
);
  logic [WIDTH:0] sum;
  // add when the consumed multiplier bit is set; the carry lands in a[WIDTH] and is shifted down
  always_comb begin
    sum = q[0] ? a + {1'b0, x} : a;
    {a_n, q_n} = {1'b0, sum, q[WIDTH-1:1]};
  end
endmodule

// File: rtl/sm_shift_add_mul.sv
// sm_shift_add_mul: sequential sign-magnitude shift-add multiplier; SMUL_EARLY_EXIT_EN stops after the top set multiplier bit
module sm_shift_add_mul
  import smul_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [op_w(WIDTH)-1:0]   multiplicand,
  input  logic [op_w(WIDTH)-1:0]   multiplier,
  output logic                     busy,
  output logic                     done,
  output logic [prod_w(WIDTH)-1:0] product
);
  localparam int CW = cnt_w(WIDTH);
  state_t state, state_n;
  logic [WIDTH:0] a, a_s;
  logic [WIDTH-1:0] q, q_s, x;
  logic [CW-1:0] cnt;
  logic sgn, last;
  logic [2*WIDTH-1:0] mag;
  smul_step #(.WIDTH(WIDTH)) u_step (.a(a), .q(q), .x(x), .a_n(a_s), .q_n(q_s));
`ifdef SMUL_EARLY_EXIT_EN
  logic [WIDTH-1:0] r, r_n;
  assign r_n = r >> 1;
  assign last = (cnt == CW'(WIDTH - 1)) || (r_n == '0);
  assign mag = {a_s[WIDTH-1:0], q_s} >> (CW'(WIDTH - 1) - cnt);
  // shadow of unconsumed multiplier bits, used only to detect early completion
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r <= '0;
    else if (state == IDLE && start) r <= multiplier[WIDTH-1:0];
    else if (state == CALC) r <= r_n;
`else
  assign last = cnt == CW'(WIDTH - 1);
  assign mag = {a_s[WIDTH-1:0], q_s};
`endif
  // next-state and handshake outputs
  always_comb begin
    state_n = state == IDLE ? (start ? CALC : IDLE) : state == CALC ? (last ? FIN : CALC) : IDLE;
    busy = state != IDLE;
    done = state == FIN;
  end
  // state, datapath and product registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      a <= '0;
      q <= '0;
      x <= '0;
      sgn <= 1'b0;
      cnt <= '0;
      product <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        a <= '0;
        q <= multiplier[WIDTH-1:0];
        x <= multiplicand[WIDTH-1:0];
        sgn <= multiplicand[op_sign(WIDTH)] ^ multiplier[op_sign(WIDTH)];
        cnt <= '0;
      end else if (state == CALC) begin
        a <= a_s;
        q <= q_s;
        cnt <= cnt + CW'(1);
        if (last) product <= {sgn, mag};
      end
    end
endmodule

// File: tb/tb_sm_shift_add_mul.sv
// tb_sm_shift_add_mul: randomized self-checking bench against an arithmetic reference model
module tb_sm_shift_add_mul;
  localparam int W = 4;
  logic clk = 0, rst_n = 0, start = 0;
  logic [W:0] multiplicand = '0, multiplier = '0;
  logic busy, done;
  logic [2*W:0] product;
  int tests = 0, fails = 0;

  sm_shift_add_mul #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .start(start), .multiplicand(multiplicand),
    .multiplier(multiplier), .busy(busy), .done(done), .product(product));

  always #5 clk = ~clk;

  function automatic logic [2*W:0] model(input logic [W:0] mc, input logic [W:0] mp);
    int unsigned m;
    m = int'(mc[W-1:0]) * int'(mp[W-1:0]);
    return {mc[W] ^ mp[W], m[2*W-1:0]};
  endfunction

  function automatic int exp_lat(input logic [W:0] mp);
    int l;
    l = W;
`ifdef SMUL_EARLY_EXIT_EN
    l = 1;
    for (int i = 0; i < W; i++) if (mp[i]) l = i + 1;
`endif
    return l;
  endfunction

  task automatic run_op(input logic [W:0] mc, input logic [W:0] mp, input string name);
    int n;
    logic [2*W:0] exp;
    exp = model(mc, mp);
    @(negedge clk);
    multiplicand = mc;
    multiplier = mp;
    start = 1;
    @(negedge clk);
    start = 0;
    multiplicand = W'($urandom);
    multiplier = W'($urandom);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL %s busy after accept: got %b want 1", name, busy); end
    n = 0;
    while (done !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    tests++;
    if (n != exp_lat(mp)) begin fails++; $display("FAIL %s latency: got %0d want %0d", name, n, exp_lat(mp)); end
    tests++;
    if (product !== exp) begin fails++; $display("FAIL %s product: got %b want %b", name, product, exp); end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL %s return to idle: done=%b busy=%b want 0 0", name, done, busy); end
    tests++;
    if (product !== exp) begin fails++; $display("FAIL %s hold: got %b want %b", name, product, exp); end
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if (busy !== 0 || done !== 0 || product !== '0) begin
      fails++; $display("FAIL reset state: busy=%b done=%b product=%b want 0 0 0", busy, done, product);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_directed();
    run_op(5'b0_1011, 5'b1_1101, "11x-13");
    tests++;
    if (product !== 9'b1_1000_1111) begin fails++; $display("FAIL plan 11x13: got %b want 110001111", product); end
    run_op(5'b0_1111, 5'b0_1111, "15x15");
    tests++;
    if (product !== 9'b0_1110_0001) begin fails++; $display("FAIL plan 15x15: got %b want 011100001", product); end
    run_op(5'b1_1111, 5'b1_0001, "-15x-1");
    run_op(5'b0_1011, 5'b1_0000, "neg zero");
    tests++;
    if (product !== 9'b1_0000_0000) begin fails++; $display("FAIL plan neg zero: got %b want 100000000", product); end
    run_op(5'b0_0011, 5'b0_0010, "3x2");
    run_op(5'b1_0000, 5'b0_1000, "zero mcand");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) run_op(5'($urandom), 5'($urandom), "random");
  endtask

  task automatic test_back_to_back();
    int dones, n;
    logic [2*W:0] exp1, exp2;
    exp1 = model(5'b0_0101, 5'b0_1001);
    exp2 = model(5'b1_0111, 5'b0_0110);
    @(negedge clk);
    multiplicand = 5'b0_0101;
    multiplier = 5'b0_1001;
    start = 1;
    @(negedge clk);
    multiplicand = 5'b1_0111;
    multiplier = 5'b0_0110;
    dones = 0;
    n = 0;
    while (done !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    dones = done;
    tests++;
    if (product !== exp1) begin fails++; $display("FAIL b2b first product: got %b want %b", product, exp1); end
    @(negedge clk);
    dones += done;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL b2b idle gap: busy=%b want 0", busy); end
    @(negedge clk);
    start = 0;
    tests++;
    if (busy !== 1'b1 || dones != 1) begin fails++; $display("FAIL b2b reaccept: busy=%b dones=%0d want 1 1", busy, dones); end
    n = 0;
    while (done !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    tests++;
    if (product !== exp2 || n != exp_lat(5'b0_0110)) begin
      fails++; $display("FAIL b2b second: product=%b lat=%0d want %b %0d", product, n, exp2, exp_lat(5'b0_0110));
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int seen;
    @(negedge clk);
    multiplicand = 5'b0_1111;
    multiplier = 5'b0_1111;
    start = 1;
    @(negedge clk);
    start = 0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    tests++;
    if (busy !== 0 || done !== 0 || product !== '0) begin
      fails++; $display("FAIL abort: busy=%b done=%b product=%b want 0 0 0", busy, done, product);
    end
    seen = 0;
    repeat (3) begin @(negedge clk); seen += done; end
    rst_n = 1;
    repeat (6) begin @(negedge clk); seen += done; end
    tests++;
    if (seen != 0 || product !== '0) begin fails++; $display("FAIL abort no done: dones=%0d product=%b want 0 0", seen, product); end
    run_op(5'b0_0110, 5'b0_0111, "after abort");
    tests++;
    if (product !== 9'b0_0010_1010) begin fails++; $display("FAIL plan 6x7: got %b want 000101010", product); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sm_shift_add_mul.md
Name: sm_shift_add_mul

Overview:
- Sequential sign-magnitude fixed-point multiplier (one-bit-per-cycle shift-add). It is the inverse-operation companion of the team's add/subtract-alternating sign-magnitude divider.
- Operand format matches the divider: MSB is the sign, the remaining WIDTH bits are the magnitude.
- Used to check divider results (quotient × divisor, plus remainder) and as a standalone arithmetic unit in the datapath.
- Interface is a start/done handshake; the result is held until the next operation.

Parameters:
- WIDTH, 4, magnitude bits per operand (4/8/16/32 supported); the operand is WIDTH+1 bits, the product is 2*WIDTH+1 bits.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- multiplicand  input  WIDTH+1  [WIDTH]=sign, [WIDTH-1:0]=magnitude
- multiplier  input  WIDTH+1  [WIDTH]=sign, [WIDTH-1:0]=magnitude
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse; product is valid from this cycle
- product  output  2*WIDTH+1  [2*WIDTH]=sign, [2*WIDTH-1:0]=magnitude

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. Assertion at any time, including mid-operation, forces state=IDLE and busy=0, done=0, product=0, and clears all internal registers. There is no partial result and no done pulse for the aborted operation.
- States: IDLE, CALC, FIN.
- IDLE:
  - start=1 at a rising edge: latch both magnitudes, compute the sign as multiplicand[WIDTH]^multiplier[WIDTH], clear the accumulator A, clear the step counter, go to CALC.
  - start=0: stay in IDLE.
- Internal registers during CALC:
  - A is WIDTH+1 bits (the extra bit is the carry).
  - Q is WIDTH bits and is initialised to the multiplier magnitude.
  - X is the multiplicand magnitude.
- CALC, one step per edge:
  - If Q[0]=1 then A=A+X.
  - Then logically shift {A,Q} right by 1, with 0 entering the top bit.
  - Counter increments.
- Leaving CALC: after step WIDTH (counter reaches WIDTH), register product={sign, A[WIDTH-1:0], Q}, go to FIN.
- FIN: done=1 for exactly this one cycle, busy=1; unconditionally go to IDLE next edge.
- Latency:
  - Let k be the accepting edge. done is high in the cycle after edge k+WIDTH. Edge k+WIDTH+1 returns to IDLE.
  - Throughput is one operation per WIDTH+2 cycles.
- Handshake:
  - start while busy=1 (including the FIN cycle) is ignored and not queued.
  - Operand inputs may change freely after the accepting edge; they have no effect until the next accept.
- Hold: product keeps its value after done until the next FIN or reset.
- Zero results: negative zero is preserved. A zero magnitude with differing operand signs gives sign=1, consistent with the divider's sign-magnitude convention.
- Arithmetic: no overflow is possible. The full 2*WIDTH-bit magnitude is always representable, and the carry bit of A is absorbed by the shift.

Optional Feature:
- Macro: SMUL_EARLY_EXIT_EN.
- Defined: the datapath keeps the unconsumed multiplier bits in a shadow register.
  - The step that consumes the most significant set multiplier bit also completes the operation. It registers product={sign, ({A,Q} after that step) >> (WIDTH - steps_done)}, then goes to FIN.
  - A zero multiplier magnitude completes on the first CALC edge, with the product magnitude equal to 0.
  - For a multiplier whose highest set bit is p, done follows edge k+max(p+1,1).
  - Results are bit-identical to the non-macro build.
- Undefined: fixed WIDTH steps as described in Behaviour.

Decomposition:
- Shared package holds:
  - the state typedef (IDLE/CALC/FIN);
  - localparam helpers for operand width (WIDTH+1), product width (2*WIDTH+1) and counter width ($clog2(WIDTH+1));
  - the sign-bit position constants, shared with the divider.
- One natural sub-module, smul_step: combinational conditional add of X into A followed by the 1-bit right shift of {A,Q}.
- The FSM, counter and output registers stay in the top module.

Test Plan:
- WIDTH=4, multiplicand=0_1011, multiplier=1_1101, start pulse -> busy=1 next cycle; done 4 edges after accept; product=9'b1_1000_1111 (11×13=143).
- 0_1111 × 0_1111 -> product=9'b0_1110_0001 (225), exercising the carry bit of A. Then 1_1111 × 1_0001 -> 9'b0_0000_1111.
- 0_1011 × 1_0000 -> product=9'b1_0000_0000 (negative zero):
  - without SMUL_EARLY_EXIT_EN, done at edge k+4;
  - with it, done at edge k+1;
  - with it, 0_0011 × 0_0010 gives done at edge k+2 and product=9'b0_0000_0110.
- Hold start high across the whole operation and change the operands mid-CALC -> exactly one done; product uses the latched operands. A new accept occurs only on the first edge back in IDLE.
- Deassert rst_n asynchronously two cycles into CALC -> busy, done and product go to 0 immediately with no done pulse. After release, a fresh start of 0_0110 × 0_0111 yields 9'b0_0010_1010 (42).
